port_master: RTL and testbench

CPU-side initiator for the word-wide I/O port bus. It accepts one IN/OUT request at a time from the execute stage and drives the `portaddr`/`portval`/`portget`/`portset` strobes to the port devices. It waits for `portack` with a bounded timeout and returns read data or an error to the core. A write to port 0 is the machine-halt request: it never reaches the bus and latches a sticky `halt`.

---
 rtl/port_master.sv | 145 ++++++++++++++
 tb/tb_port_master.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/port_master.sv
// port_master: single-outstanding IN/OUT initiator for the port bus.
// A write to port 0 is a halt request and never reaches the bus.
module port_master #(
  parameter int WORD_WIDTH    = 16,
  parameter int TIMEOUT       = 255,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [WORD_WIDTH-1:0] req_addr,
  input  logic [WORD_WIDTH-1:0] req_data,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [WORD_WIDTH-1:0] resp_data,
  output logic                  resp_error,
  output logic                  halt,
  output logic [WORD_WIDTH-1:0] portaddr,
  output logic [WORD_WIDTH-1:0] portval,
  output logic                  portget,
  output logic                  portset,
  input  logic [WORD_WIDTH-1:0] portout,
  input  logic                  portack
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    HALTED
  } state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] TMAX = TIMEOUT_WIDTH'(TIMEOUT);

  state_t                   state, state_nx;
  logic [TIMEOUT_WIDTH-1:0] timer, timer_nx;
  logic                     halt_pend, halt_pend_nx;
  logic                     resp_valid_nx;
  logic [WORD_WIDTH-1:0]    resp_data_nx;
  logic                     resp_error_nx;
  logic                     halt_nx;
  logic [WORD_WIDTH-1:0]    portaddr_nx, portval_nx;
  logic                     portget_nx, portset_nx;

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      halt_pend  <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_error <= 1'b0;
      halt       <= 1'b0;
      portaddr   <= '0;
      portval    <= '0;
      portget    <= 1'b0;
      portset    <= 1'b0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      halt_pend  <= halt_pend_nx;
      resp_valid <= resp_valid_nx;
      resp_data  <= resp_data_nx;
      resp_error <= resp_error_nx;
      halt       <= halt_nx;
      portaddr   <= portaddr_nx;
      portval    <= portval_nx;
      portget    <= portget_nx;
      portset    <= portset_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    timer_nx      = timer;
    halt_pend_nx  = halt_pend;
    resp_valid_nx = 1'b0;
    resp_data_nx  = resp_data;
    resp_error_nx = resp_error;
    halt_nx       = halt;
    portaddr_nx   = portaddr;
    portval_nx    = portval;
    portget_nx    = portget;
    portset_nx    = portset;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          resp_data_nx  = '0;
          resp_error_nx = 1'b0;
          if (req_write && req_addr == '0) begin
            halt_pend_nx  = 1'b1;
            resp_valid_nx = 1'b1;
            state_nx      = RESP;
          end else begin
            halt_pend_nx = 1'b0;
            portaddr_nx  = req_addr;
            portval_nx   = req_write ? req_data : '0;
            portget_nx   = !req_write;
            portset_nx   = req_write;
            timer_nx     = '0;
            state_nx     = ACCESS;
          end
        end
      end
      ACCESS: begin
        // ack wins over a timeout expiring on the same edge
        if (portack) begin
          resp_data_nx  = portget ? portout : '0;
          resp_error_nx = 1'b0;
          resp_valid_nx = 1'b1;
          portget_nx    = 1'b0;
          portset_nx    = 1'b0;
          state_nx      = RESP;
        end else if (timer == TMAX) begin
          resp_data_nx  = '0;
          resp_error_nx = 1'b1;
          resp_valid_nx = 1'b1;
          portget_nx    = 1'b0;
          portset_nx    = 1'b0;
          state_nx      = RESP;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      RESP: begin
        if (halt_pend) begin
          halt_nx  = 1'b1;
          state_nx = HALTED;
        end else begin
          state_nx = IDLE;
        end
      end
      HALTED: begin
        state_nx = HALTED;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_port_master.sv
// Scoreboard bench for port_master: random IN/OUT accesses against a
// behavioural device model, plus halt and mid-access reset cases.
module tb_port_master;

  localparam int WW = 16;
  localparam int TO = 4;

  typedef struct {
    logic [WW-1:0] data;
    logic          err;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_write;
  logic [WW-1:0] req_addr, req_data;
  logic          req_ready, resp_valid, resp_error, halt;
  logic [WW-1:0] resp_data, portaddr, portval, portout;
  logic          portget, portset, portack;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sbq[$];

  port_master #(
    .WORD_WIDTH(WW),
    .TIMEOUT(TO),
    .TIMEOUT_WIDTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_data(req_data),
    .req_ready(req_ready),
    .resp_valid(resp_valid),
    .resp_data(resp_data),
    .resp_error(resp_error),
    .halt(halt),
    .portaddr(portaddr),
    .portval(portval),
    .portget(portget),
    .portset(portset),
    .portout(portout),
    .portack(portack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && resp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected none (cycle %0d)",
                 cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("resp_data", 32'(resp_data), 32'(e.data));
        chk("resp_error", 32'(resp_error), 32'(e.err));
        chk("resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // d = strobe cycle on which the device acks; d > TO+1 means never.
  task automatic access(input logic w, input logic [WW-1:0] a,
                        input logic [WW-1:0] dat, input int d,
                        input logic [WW-1:0] rd);
    int   waitc;
    int   n;
    logic hp;
    exp_t e;
    hp = w && (a == '0);
    waitc = 0;
    while (req_ready !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk("ready_wait", 32'(req_ready), 32'(1));
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_data  = dat;
    n = hp ? 0 : ((d < TO + 1) ? d : TO + 1);
    e.err  = !hp && (d > TO + 1);
    e.data = (hp || w || e.err) ? '0 : rd;
    e.cyc  = cyc + 1 + n;
    sbq.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = WW'($urandom);
    req_data  = WW'($urandom);
    if (!hp) begin
      for (int j = 1; j <= n; j++) begin
        chk("strobe_hi", 32'({portget, portset}), w ? 32'd1 : 32'd2);
        chk("portaddr", 32'(portaddr), 32'(a));
        chk("portval", 32'(portval), w ? 32'(dat) : 32'd0);
        if (j == d) begin
          portack = 1'b1;
          portout = rd;
        end else begin
          portout = WW'($urandom);
        end
        @(negedge clk);
      end
      portack = 1'b0;
      chk("strobe_lo", 32'({portget, portset}), 32'd0);
      chk("portaddr_hold", 32'(portaddr), 32'(a));
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = '0;
    req_data  = 16'hFFFF;
    portack   = 1'b0;
    portout   = '0;
    repeat (3) @(negedge clk);
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_outs",
        32'({resp_valid, resp_error, halt, portget, portset}), 32'd0);
    chk("idle_bus", {portaddr, portval}, 32'd0);
    chk("idle_data", 32'(resp_data), 32'd0);
    chk("idle_ready", 32'(req_ready), 32'd1);

    // directed cases
    access(1'b0, 16'd5, 16'd0, 3, 16'h1234);
    access(1'b1, 16'd7, 16'h00AB, 1, 16'h5555);
    access(1'b0, 16'd9, 16'd0, 99, 16'h7777);
    access(1'b1, 16'd3, 16'hBEEF, TO + 1, 16'h0);
    access(1'b0, 16'd0, 16'd0, 2, 16'hC0DE);

    // randomized accesses, port 0 writes steered away
    for (int i = 0; i < 40; i++) begin
      logic          w;
      logic [WW-1:0] a;
      w = 1'($urandom);
      a = WW'($urandom_range(0, 15));
      if (w && a == '0) a = 16'd1;
      access(w, a, WW'($urandom), int'($urandom_range(1, TO + 3)),
             WW'($urandom));
    end

    // reset in the middle of an access
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'd11;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_strobe_hi", 32'(portget), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_strobe_lo", 32'({portget, portset}), 32'd0);
    repeat (TO + 2) begin
      @(negedge clk);
      chk("mid_no_resp", 32'(resp_valid), 32'd0);
    end
    access(1'b0, 16'd11, 16'd0, 2, 16'hA5A5);

    // halt
    access(1'b1, 16'd0, 16'h1111, 1, 16'h0);
    chk("halt_no_strobe", 32'({portget, portset}), 32'd0);
    chk("halt_not_yet", 32'(halt), 32'd0);
    @(negedge clk);
    chk("halt_set", 32'(halt), 32'd1);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'd4;
    repeat (6) begin
      @(negedge clk);
      chk("halted_ready", 32'(req_ready), 32'd0);
      chk("halted_strobe", 32'({portget, portset}), 32'd0);
      chk("halted_sticky", 32'(halt), 32'd1);
    end
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_clears_halt", 32'(halt), 32'd0);
    access(1'b1, 16'd2, 16'h4242, 2, 16'h0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
